// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader that writes the instruction memory.
// The CPU is held in reset from Start until the load succeeds.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        Byte_in,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic              IM_wr,
  output logic [ADDR_W-1:0] IM_addr,
  output logic [WORD_W-1:0] IM_data,
  output logic              Cpu_hold,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] index;
  logic [7:0]        hi_byte;
  logic [7:0]        checksum;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              accept;
  logic              hdr_ok;
  logic              last_word;
  logic              restart;

  assign accept    = Byte_valid && Byte_ready;
  assign hdr_ok    = (Byte_in != 8'd0) && (Byte_in <= DEPTH_B);
  assign last_word = (CNT_W'(index) == count - CNT_W'(1));
  assign restart   = Start && ((state == S_IDLE) || (state == S_ERR));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_HDR;
      S_HDR:   if (accept) state_nxt = hdr_ok ? S_HI : S_ERR;
      S_HI:    if (accept) state_nxt = S_LO;
      S_LO:    if (accept) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_word ? S_CSUM : S_HI;
      S_CSUM:  if (accept) state_nxt = (Byte_in == checksum) ? S_DONE : S_ERR;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   if (Start) state_nxt = S_HDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every status output is a pure decode of the registered state.
  always_comb begin
    Byte_ready = 1'b0;
    IM_wr      = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    Error      = 1'b0;
    Cpu_hold   = (state != S_IDLE);
    case (state)
      S_HDR, S_HI, S_LO, S_CSUM: begin
        Byte_ready = 1'b1;
        Busy       = 1'b1;
      end
      S_WRITE: begin
        IM_wr = 1'b1;
        Busy  = 1'b1;
      end
      S_DONE:  Done  = 1'b1;
      S_ERR:   Error = 1'b1;
      default: ;
    endcase
  end

  // IM_addr/IM_data are captured with the low byte so they stay put outside WRITE.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= S_IDLE;
      count    <= '0;
      index    <= '0;
      hi_byte  <= '0;
      checksum <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        checksum <= '0;
        index    <= '0;
        addr_q   <= '0;
      end
      if (state == S_HDR && accept && hdr_ok)
        count <= Byte_in[CNT_W-1:0];
      if (state == S_HI && accept) begin
        hi_byte  <= Byte_in;
        checksum <= checksum ^ Byte_in;
      end
      if (state == S_LO && accept) begin
        data_q   <= WORD_W'({hi_byte, Byte_in});
        addr_q   <= index;
        checksum <= checksum ^ Byte_in;
      end
      if (state == S_WRITE && !last_word)
        index <= index + ADDR_W'(1);
    end
  end

  assign IM_addr = addr_q;
  assign IM_data = data_q;

endmodule
